mod_n_sequencer: RTL and testbench

Parametrised N-state ring sequencer: the successor to the fixed three-state cycling FSM. Adds a runtime-loadable modulus, advance enable, up/down direction, synchronous clear, a wrap strobe and an optional one-hot phase bus. It sits beside timing and control logic that needs a repeating phase count with a "home" flag, `q`. With `MAX_STATES=3` and `mod_ld=0`, `en=1`, `dir=1` it reproduces the legacy 0→1→2→0 ring, with `q` high in state 0.

---
 rtl/mod_n_sequencer.sv | 112 +++++++++++
 tb/tb_mod_n_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mod_n_sequencer.sv
// Runtime-modulus ring sequencer with enable, up/down direction, clear, wrap strobe
// and home flag q. Optional one-hot phase register enabled by MOD_SEQ_ONEHOT_EN.
module mod_n_sequencer #(
  parameter int unsigned MAX_STATES = 8,
  parameter int unsigned SW         = $clog2(MAX_STATES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  clr,
  input  logic                  mod_ld,
  input  logic [SW-1:0]         mod_in,
  output logic [SW-1:0]         state,
  output logic [SW-1:0]         last,
  output logic                  q,
  output logic                  wrap,
  output logic [MAX_STATES-1:0] phase
);

  localparam logic [SW-1:0] LAST_MAX = SW'(MAX_STATES - 1);
  localparam logic [SW-1:0] LAST_MIN = SW'(1);

  logic [SW-1:0] r_state;
  logic [SW-1:0] r_last;
  logic          r_wrap;
  logic [SW-1:0] w_clamp;
  logic [SW-1:0] w_state_nxt;
  logic [SW-1:0] w_last_nxt;
  logic          w_wrap_nxt;

  // Clamp the requested last index into [1, MAX_STATES-1]; compared one bit wider
  // so non-power-of-two limits are handled without a constant-range compare.
  always_comb begin
    w_clamp = mod_in;
    if (mod_in == '0) begin
      w_clamp = LAST_MIN;
    end else if ({1'b0, mod_in} > (SW+1)'(MAX_STATES - 1)) begin
      w_clamp = LAST_MAX;
    end
  end

  // Next-state selection: clr > mod_ld > en > hold.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_wrap_nxt  = 1'b0;
    if (clr) begin
      w_state_nxt = '0;
    end else if (mod_ld) begin
      w_last_nxt = w_clamp;
      if (r_state > w_clamp) begin
        w_state_nxt = '0;
      end
    end else if (en) begin
      if (dir) begin
        if (r_state == r_last) begin
          w_state_nxt = '0;
          w_wrap_nxt  = 1'b1;
        end else if (r_state > r_last) begin
          w_state_nxt = '0;
        end else begin
          w_state_nxt = r_state + SW'(1);
        end
      end else begin
        if (r_state == '0) begin
          w_state_nxt = r_last;
          w_wrap_nxt  = 1'b1;
        end else if (r_state > r_last) begin
          w_state_nxt = r_last;
        end else begin
          w_state_nxt = r_state - SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= '0;
      r_last  <= LAST_MAX;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

`ifdef MOD_SEQ_ONEHOT_EN
  logic [MAX_STATES-1:0] r_phase;

  // One-hot image of the state, registered on the same edge as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= MAX_STATES'(1);
    end else begin
      r_phase <= MAX_STATES'(1) << w_state_nxt;
    end
  end

  assign phase = r_phase;
`else
  assign phase = '0;
`endif

  assign state = r_state;
  assign last  = r_last;
  assign wrap  = r_wrap;
  assign q     = (r_state == '0);

endmodule

// File: tb/tb_mod_n_sequencer.sv
// Directed bench for mod_n_sequencer: an 8-state instance plus a 3-state legacy-ring instance.
module tb_mod_n_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, dir, clr, mod_ld;
  logic [2:0] mod_in;
  logic [2:0] state, last;
  logic       q, wrap;
  logic [7:0] phase;

  logic       l_en, l_dir, l_clr, l_mod_ld;
  logic [1:0] l_mod_in;
  logic [1:0] l_state, l_last;
  logic       l_q, l_wrap;
  logic [2:0] l_phase;

  int total = 0;
  int bad   = 0;
  int m_state, m_last, m_wrap;

  always #5 clk = ~clk;

  mod_n_sequencer #(.MAX_STATES(8)) u_dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .clr(clr), .mod_ld(mod_ld),
    .mod_in(mod_in), .state(state), .last(last), .q(q), .wrap(wrap), .phase(phase)
  );

  mod_n_sequencer #(.MAX_STATES(3)) u_leg (
    .clk(clk), .reset(reset), .en(l_en), .dir(l_dir), .clr(l_clr), .mod_ld(l_mod_ld),
    .mod_in(l_mod_in), .state(l_state), .last(l_last), .q(l_q), .wrap(l_wrap), .phase(l_phase)
  );

  function automatic logic [31:0] exp_phase(int s, int width);
`ifdef MOD_SEQ_ONEHOT_EN
    logic [31:0] one = 32'd1;
    if (s >= width) return 32'd0;
    return one << s;
`else
    if (width < 0) return 32'd1;
    return 32'd0 + 32'(s & 0);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input int s, input int l, input int w);
    check({tag, ".state"}, 32'(state), 32'(s));
    check({tag, ".last"},  32'(last),  32'(l));
    check({tag, ".wrap"},  32'(wrap),  32'(w));
    check({tag, ".q"},     32'(q),     32'(s == 0));
    check({tag, ".phase"}, 32'(phase), exp_phase(s, 8));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference step written in modular-arithmetic form.
  task automatic model_step(input logic i_en, input logic i_dir, input logic i_clr,
                            input logic i_ld, input int i_min);
    if (i_clr) begin
      m_state = 0; m_wrap = 0;
    end else if (i_ld) begin
      m_last = (i_min == 0) ? 1 : i_min;
      if (m_state > m_last) m_state = 0;
      m_wrap = 0;
    end else if (i_en) begin
      if (i_dir) begin
        m_wrap  = (m_state == m_last) ? 1 : 0;
        m_state = (m_state + 1) % (m_last + 1);
      end else begin
        m_wrap  = (m_state == 0) ? 1 : 0;
        m_state = (m_state + m_last) % (m_last + 1);
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  initial begin
    int exp_dn[6];
    int en_dn[6];
    reset = 1'b1; en = 1'b0; dir = 1'b1; clr = 1'b0; mod_ld = 1'b0; mod_in = 3'd0;
    l_en = 1'b0; l_dir = 1'b1; l_clr = 1'b0; l_mod_ld = 1'b0; l_mod_in = 2'd0;
    #3;
    chk_dut("reset", 0, 7, 0);
    check("leg_reset.last", 32'(l_last), 32'd2);
    #9;
    reset = 1'b0;

    // Legacy 0->1->2->0 ring on the 3-state instance.
    l_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("legacy%0d.state", i), 32'(l_state), 32'((i + 1) % 3));
      check($sformatf("legacy%0d.q", i),     32'(l_q),     32'(((i + 1) % 3) == 0));
      check($sformatf("legacy%0d.wrap", i),  32'(l_wrap),  32'(((i + 1) % 3) == 0));
      check($sformatf("legacy%0d.phase", i), 32'(l_phase), exp_phase((i + 1) % 3, 3));
    end
    l_en = 1'b0;

    // Down count with a two-cycle hold.
    exp_dn = '{7, 6, 5, 5, 5, 4};
    en_dn  = '{1, 1, 1, 0, 0, 1};
    dir = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en = en_dn[i][0];
      tick();
      chk_dut($sformatf("down%0d", i), exp_dn[i], 7, (i == 0) ? 1 : 0);
    end

    // Climb to 6, then load last=3 which lies below the current state.
    dir = 1'b1; en = 1'b1;
    tick(); chk_dut("up5", 5, 7, 0);
    tick(); chk_dut("up6", 6, 7, 0);
    mod_ld = 1'b1; mod_in = 3'd3;
    tick(); chk_dut("ld3", 0, 3, 0);
    mod_ld = 1'b0;
    tick(); chk_dut("m3_1", 1, 3, 0);
    tick(); chk_dut("m3_2", 2, 3, 0);
    tick(); chk_dut("m3_3", 3, 3, 0);
    tick(); chk_dut("m3_wrap", 0, 3, 1);

    // Clamping of the loaded index.
    en = 1'b0; mod_ld = 1'b1; mod_in = 3'd0;
    tick(); chk_dut("clamp_lo", 0, 1, 0);
    mod_in = 3'(15);
    tick(); chk_dut("clamp_hi", 0, 7, 0);

    // clr beats mod_ld and en.
    mod_ld = 1'b0; en = 1'b1;
    tick(); chk_dut("pre_clr1", 1, 7, 0);
    tick(); chk_dut("pre_clr2", 2, 7, 0);
    clr = 1'b1; mod_ld = 1'b1; mod_in = 3'd3;
    tick(); chk_dut("clr_prio", 0, 7, 0);
    clr = 1'b0;

    // Reach state 4 with last 5, then reset between edges.
    en = 1'b0; mod_in = 3'd5;
    tick(); chk_dut("ld5", 0, 5, 0);
    mod_ld = 1'b0; en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_dut($sformatf("to4_%0d", i), i, 5, 0);
    end
    en = 1'b0;
    #2 reset = 1'b1;
    #1 chk_dut("async_rst", 0, 7, 0);
    @(negedge clk);
    reset = 1'b0; en = 1'b1; dir = 1'b1;
    tick(); chk_dut("post_rst", 1, 7, 0);

    // Randomised en/dir/clr/mod_ld run against the reference step.
    m_state = 1; m_last = 7; m_wrap = 0;
    for (int i = 0; i < 60; i++) begin
      en     = 1'($urandom_range(0, 1));
      dir    = 1'($urandom_range(0, 1));
      clr    = ($urandom_range(0, 9) == 0);
      mod_ld = ($urandom_range(0, 5) == 0);
      mod_in = 3'($urandom_range(0, 7));
      model_step(en, dir, clr, mod_ld, int'(mod_in));
      tick();
      chk_dut($sformatf("rnd%0d", i), m_state, m_last, m_wrap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
